// File: rtl/dram_responder.sv
// dram_responder: memory-side stand-in for a DDR3 command/data interface.
// It accepts read and write commands plus write data, stores whole words in an
// internal array, and returns read data in command order after ReadLatency cycles.
//
// Ports
//   Clock, Reset                 clock, synchronous active-high reset
//   DRAMCommandAddress/Command   command address and code (0 = write, 1 = read)
//   DRAMCommandValid/Ready       command handshake
//   DRAMWriteData/Valid/Ready    write-data handshake, paired in order with write commands
//   DRAMReadData/Valid           returned read word, no backpressure
//   IllegalCmd                   sticky flag, set when a code other than read/write retires

module dram_responder_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [Width-1:0] head,
  output logic             not_empty,
  input  logic             pop
);
  localparam int PW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic [PW:0]      count_next;
  logic             push;

  assign push      = push_valid & push_ready;
  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

  // Ready comes from the post-edge count, so a full queue refuses a push even
  // in a cycle where it is also popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      push_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      push_ready <= (count_next != (PW+1)'(Depth));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

module dram_responder #(
  parameter int DDRAWidth    = 28,
  parameter int DDRCWidth    = 3,
  parameter int DDRDWidth    = 512,
  parameter int AddrLSB      = 3,
  parameter int MemAWidth    = 10,
  parameter int CmdFIFODepth = 8,
  parameter int WDFIFODepth  = 8,
  parameter int ReadLatency  = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRAWidth-1:0] DRAMCommandAddress,
  input  logic [DDRCWidth-1:0] DRAMCommand,
  input  logic                 DRAMCommandValid,
  output logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMReadData,
  output logic                 DRAMReadDataValid,
  input  logic [DDRDWidth-1:0] DRAMWriteData,
  input  logic                 DRAMWriteDataValid,
  output logic                 DRAMWriteDataReady,
  output logic                 IllegalCmd
);
  localparam int MemDepth = 2**MemAWidth;
  localparam int CmdW     = DDRCWidth + MemAWidth;

  logic [DDRDWidth-1:0] mem [MemDepth];

  logic [CmdW-1:0]      cmd_head;
  logic                 cmd_ne;
  logic [DDRCWidth-1:0] head_cmd;
  logic [MemAWidth-1:0] head_idx;
  logic [DDRDWidth-1:0] wd_head;
  logic                 wd_ne;

  logic cmd_pop;
  logic wd_pop;
  logic rd_issue;
  logic ill_seen;

  logic [ReadLatency-1:0] pipe_valid;
  logic [DDRDWidth-1:0]   pipe_data [ReadLatency];

  // Address bits outside the word index only alias onto the array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{DRAMCommandAddress[DDRAWidth-1:AddrLSB+MemAWidth],
                              DRAMCommandAddress[AddrLSB-1:0]};

  // Only the word index is queued with the code; that is all the scheduler needs.
  dram_responder_fifo #(.Width(CmdW), .Depth(CmdFIFODepth)) u_cmd_fifo (
    .clk        (Clock),
    .rst        (Reset),
    .push_data  ({DRAMCommand, DRAMCommandAddress[AddrLSB+MemAWidth-1:AddrLSB]}),
    .push_valid (DRAMCommandValid),
    .push_ready (DRAMCommandReady),
    .head       (cmd_head),
    .not_empty  (cmd_ne),
    .pop        (cmd_pop)
  );

  dram_responder_fifo #(.Width(DDRDWidth), .Depth(WDFIFODepth)) u_wd_fifo (
    .clk        (Clock),
    .rst        (Reset),
    .push_data  (DRAMWriteData),
    .push_valid (DRAMWriteDataValid),
    .push_ready (DRAMWriteDataReady),
    .head       (wd_head),
    .not_empty  (wd_ne),
    .pop        (wd_pop)
  );

  assign {head_cmd, head_idx} = cmd_head;

  // In-order retirement of the command head; a write waits for its data word.
  always_comb begin
    cmd_pop  = 1'b0;
    wd_pop   = 1'b0;
    rd_issue = 1'b0;
    ill_seen = 1'b0;
    if (cmd_ne) begin
      if (head_cmd == DDRCWidth'(0)) begin
        if (wd_ne) begin
          cmd_pop = 1'b1;
          wd_pop  = 1'b1;
        end
      end else if (head_cmd == DDRCWidth'(1)) begin
        cmd_pop  = 1'b1;
        rd_issue = 1'b1;
      end else begin
        cmd_pop  = 1'b1;
        ill_seen = 1'b1;
      end
    end
  end

  // The array survives reset; only the write on the reset edge is suppressed.
  always_ff @(posedge Clock) begin
    if (!Reset && wd_pop) mem[head_idx] <= wd_head;
  end

  // Each stage loads data only with a valid, so the last stage holds the most
  // recently returned word between reads.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < ReadLatency; i++) pipe_data[i] <= '0;
      IllegalCmd <= 1'b0;
    end else begin
      pipe_valid[0] <= rd_issue;
      if (rd_issue) pipe_data[0] <= mem[head_idx];
      for (int i = 1; i < ReadLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
      if (ill_seen) IllegalCmd <= 1'b1;
    end
  end

  assign DRAMReadDataValid = pipe_valid[ReadLatency-1];
  assign DRAMReadData      = pipe_data[ReadLatency-1];
endmodule

// File: tb/tb_dram_responder.sv
module tb_dram_responder;
  localparam int AW = 28;
  localparam int CW = 3;
  localparam int DW = 512;
  localparam int L  = 4;
  localparam int QD = 8;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [AW-1:0] DRAMCommandAddress;
  logic [CW-1:0] DRAMCommand;
  logic          DRAMCommandValid;
  logic          DRAMCommandReady;
  logic [DW-1:0] DRAMReadData;
  logic          DRAMReadDataValid;
  logic [DW-1:0] DRAMWriteData;
  logic          DRAMWriteDataValid;
  logic          DRAMWriteDataReady;
  logic          IllegalCmd;

  int total = 0;
  int bad   = 0;

  dram_responder dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .DRAMCommandAddress (DRAMCommandAddress),
    .DRAMCommand        (DRAMCommand),
    .DRAMCommandValid   (DRAMCommandValid),
    .DRAMCommandReady   (DRAMCommandReady),
    .DRAMReadData       (DRAMReadData),
    .DRAMReadDataValid  (DRAMReadDataValid),
    .DRAMWriteData      (DRAMWriteData),
    .DRAMWriteDataValid (DRAMWriteDataValid),
    .DRAMWriteDataReady (DRAMWriteDataReady),
    .IllegalCmd         (IllegalCmd)
  );

  always #5 Clock = ~Clock;

  // Reference model: queues of accepted commands and data, retired one per edge
  // by the in-order rules, with each read scheduled to appear L-1 edges after issue.
  typedef struct { logic [CW-1:0] cmd; int idx; } cmd_t;
  typedef struct { int unsigned due; logic [DW-1:0] data; bit known; } rd_t;

  int unsigned   edge_cnt = 0;
  logic [DW-1:0] m_mem [int];
  cmd_t          m_cmdq [$];
  logic [DW-1:0] m_wdq [$];
  rd_t           m_rdq [$];
  bit            m_cmd_ready = 1'b0;
  bit            m_wd_ready  = 1'b0;
  bit            m_illegal   = 1'b0;
  bit            m_out_valid = 1'b0;
  bit            m_out_known = 1'b1;
  logic [DW-1:0] m_out_data  = '0;

  initial begin
    cmd_t c;
    rd_t  r;
    forever begin
      @(posedge Clock);
      edge_cnt++;
      if (Reset) begin
        m_cmdq.delete();
        m_wdq.delete();
        m_rdq.delete();
        m_cmd_ready = 1'b0;
        m_wd_ready  = 1'b0;
        m_illegal   = 1'b0;
        m_out_valid = 1'b0;
        m_out_known = 1'b1;
        m_out_data  = '0;
      end else begin
        if (m_cmdq.size() != 0) begin
          c = m_cmdq[0];
          if (c.cmd == 3'd0) begin
            if (m_wdq.size() != 0) begin
              m_mem[c.idx] = m_wdq.pop_front();
              void'(m_cmdq.pop_front());
            end
          end else if (c.cmd == 3'd1) begin
            r.due   = edge_cnt + L - 1;
            r.known = m_mem.exists(c.idx);
            r.data  = r.known ? m_mem[c.idx] : '0;
            m_rdq.push_back(r);
            void'(m_cmdq.pop_front());
          end else begin
            m_illegal = 1'b1;
            void'(m_cmdq.pop_front());
          end
        end
        if (DRAMCommandValid && m_cmd_ready)
          m_cmdq.push_back('{DRAMCommand, int'(DRAMCommandAddress[12:3])});
        if (DRAMWriteDataValid && m_wd_ready)
          m_wdq.push_back(DRAMWriteData);
        m_cmd_ready = (m_cmdq.size() != QD);
        m_wd_ready  = (m_wdq.size() != QD);
        if (m_rdq.size() != 0 && m_rdq[0].due == edge_cnt) begin
          r = m_rdq.pop_front();
          m_out_valid = 1'b1;
          m_out_data  = r.data;
          m_out_known = r.known;
        end else begin
          m_out_valid = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic cv, input logic [CW-1:0] c, input logic [AW-1:0] a,
                       input logic wv, input logic [DW-1:0] wd);
    DRAMCommandValid   = cv;
    DRAMCommand        = c;
    DRAMCommandAddress = a;
    DRAMWriteDataValid = wv;
    DRAMWriteData      = wd;
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle(3);
    total++;
    if (DRAMCommandReady !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b expected 0", DRAMCommandReady); end
    total++;
    if (DRAMWriteDataReady !== 1'b0) begin bad++; $display("FAIL reset_wd_ready: got %b expected 0", DRAMWriteDataReady); end
    total++;
    if (DRAMReadDataValid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b expected 0", DRAMReadDataValid); end
    total++;
    if (DRAMReadData !== '0) begin bad++; $display("FAIL reset_rd_data: got %h expected 0", DRAMReadData); end
    total++;
    if (IllegalCmd !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b expected 0", IllegalCmd); end
    Reset = 1'b0;
    idle(1);
    total++;
    if (DRAMCommandReady !== 1'b1) begin bad++; $display("FAIL post_reset_cmd_ready: got %b expected 1", DRAMCommandReady); end
    total++;
    if (DRAMWriteDataReady !== 1'b1) begin bad++; $display("FAIL post_reset_wd_ready: got %b expected 1", DRAMWriteDataReady); end
  endtask

  task automatic test_read_latency();
    logic [DW-1:0] a5 = {64{8'hA5}};
    int unsigned n;
    bit exp_v;
    drive(1'b1, 3'd0, 28'h10, 1'b1, a5);
    drive(1'b1, 3'd1, 28'h10, 1'b0, '0);
    n = edge_cnt;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      exp_v = (edge_cnt == n + 4);
      total++;
      if (DRAMReadDataValid !== exp_v) begin
        bad++; $display("FAIL latency_valid edge+%0d: got %b expected %b", edge_cnt - n, DRAMReadDataValid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (DRAMReadData !== a5) begin bad++; $display("FAIL latency_data: got %h expected %h", DRAMReadData, a5); end
      end
    end
    total++;
    if (IllegalCmd !== 1'b0) begin bad++; $display("FAIL latency_illegal: got %b expected 0", IllegalCmd); end
  endtask

  task automatic test_data_first();
    bit found = 1'b0;
    drive(1'b0, 3'd0, 28'h0, 1'b1, 512'h1);
    drive(1'b0, 3'd0, 28'h0, 1'b1, 512'h2);
    idle(1);
    drive(1'b1, 3'd0, 28'h0, 1'b0, '0);
    drive(1'b1, 3'd0, 28'h8, 1'b0, '0);
    drive(1'b1, 3'd1, 28'h8, 1'b0, '0);
    drive(1'b1, 3'd1, 28'h0, 1'b0, '0);
    for (int i = 0; i < 20 && !found; i++) begin
      idle(1);
      if (DRAMReadDataValid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL data_first_timeout: got no valid expected valid within 20 cycles");
    end else begin
      total++;
      if (DRAMReadData !== 512'h2) begin bad++; $display("FAIL data_first_rd1: got %h expected 2", DRAMReadData); end
      idle(1);
      total++;
      if (DRAMReadDataValid !== 1'b1) begin bad++; $display("FAIL data_first_back_to_back: got %b expected 1", DRAMReadDataValid); end
      total++;
      if (DRAMReadData !== 512'h1) begin bad++; $display("FAIL data_first_rd2: got %h expected 1", DRAMReadData); end
    end
  endtask

  task automatic test_write_stall();
    bit found = 1'b0;
    int unsigned d;
    int unsigned seen = 0;
    drive(1'b1, 3'd0, 28'h18, 1'b0, '0);
    drive(1'b1, 3'd1, 28'h18, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      total++;
      if (DRAMReadDataValid !== 1'b0) begin bad++; $display("FAIL stall_no_valid cycle %0d: got %b expected 0", i, DRAMReadDataValid); end
    end
    drive(1'b0, 3'd0, 28'h0, 1'b1, 512'h77);
    d = edge_cnt;
    for (int i = 0; i < 12 && !found; i++) begin
      idle(1);
      if (DRAMReadDataValid === 1'b1) begin found = 1'b1; seen = edge_cnt; end
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL stall_timeout: got no valid expected valid within 12 cycles");
    end else begin
      total++;
      if (seen != d + 5) begin bad++; $display("FAIL stall_latency: got edge+%0d expected edge+5", seen - d); end
      total++;
      if (DRAMReadData !== 512'h77) begin bad++; $display("FAIL stall_data: got %h expected 77", DRAMReadData); end
    end
  endtask

  task automatic test_cmd_full();
    bit found = 1'b0;
    bit exp_r;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 3'd0, 28'((10 + i) * 8), 1'b0, '0);
      exp_r = (i < 7);
      total++;
      if (DRAMCommandReady !== exp_r) begin bad++; $display("FAIL full_ready push %0d: got %b expected %b", i, DRAMCommandReady, exp_r); end
    end
    drive(1'b0, 3'd0, 28'h0, 1'b1, 512'h100);
    total++;
    if (DRAMCommandReady !== 1'b0) begin bad++; $display("FAIL full_ready_data_edge: got %b expected 0", DRAMCommandReady); end
    idle(1);
    total++;
    if (DRAMCommandReady !== 1'b1) begin bad++; $display("FAIL full_ready_reassert: got %b expected 1", DRAMCommandReady); end
    for (int i = 0; i < 7; i++) drive(1'b0, 3'd0, 28'h0, 1'b1, 512'(200 + i));
    idle(3);
    drive(1'b1, 3'd1, 28'(10 * 8), 1'b0, '0);
    drive(1'b1, 3'd1, 28'(17 * 8), 1'b0, '0);
    for (int i = 0; i < 15 && !found; i++) begin
      idle(1);
      if (DRAMReadDataValid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL full_readback_timeout: got no valid expected valid within 15 cycles");
    end else begin
      total++;
      if (DRAMReadData !== 512'h100) begin bad++; $display("FAIL full_readback_idx10: got %h expected 100", DRAMReadData); end
      idle(1);
      total++;
      if (DRAMReadData !== 512'd206) begin bad++; $display("FAIL full_readback_idx17: got %h expected %h", DRAMReadData, 512'd206); end
    end
  endtask

  task automatic test_illegal();
    bit found = 1'b0;
    drive(1'b1, 3'b111, 28'h0, 1'b0, '0);
    idle(2);
    total++;
    if (IllegalCmd !== 1'b1) begin bad++; $display("FAIL illegal_set: got %b expected 1", IllegalCmd); end
    drive(1'b1, 3'd1, 28'h0, 1'b0, '0);
    for (int i = 0; i < 12 && !found; i++) begin
      idle(1);
      if (DRAMReadDataValid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL illegal_read_timeout: got no valid expected valid within 12 cycles");
    end else begin
      total++;
      if (DRAMReadData !== 512'h1) begin bad++; $display("FAIL illegal_idx0_kept: got %h expected 1", DRAMReadData); end
    end
    idle(5);
    total++;
    if (IllegalCmd !== 1'b1) begin bad++; $display("FAIL illegal_sticky: got %b expected 1", IllegalCmd); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d6 = {16{32'hDEADBEEF}};
    bit found = 1'b0;
    int spurious = 0;
    drive(1'b1, 3'd0, 28'h100, 1'b1, d6);
    idle(3);
    drive(1'b1, 3'd1, 28'h100, 1'b0, '0);
    drive(1'b1, 3'd1, 28'h10, 1'b0, '0);
    drive(1'b1, 3'd1, 28'h8, 1'b0, '0);
    Reset = 1'b1;
    idle(1);
    if (DRAMReadDataValid === 1'b1) spurious++;
    total++;
    if (DRAMCommandReady !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: got %b expected 0", DRAMCommandReady); end
    idle(1);
    if (DRAMReadDataValid === 1'b1) spurious++;
    Reset = 1'b0;
    idle(1);
    total++;
    if (DRAMCommandReady !== 1'b1) begin bad++; $display("FAIL mid_reset_ready_after: got %b expected 1", DRAMCommandReady); end
    total++;
    if (IllegalCmd !== 1'b0) begin bad++; $display("FAIL mid_reset_illegal_cleared: got %b expected 0", IllegalCmd); end
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (DRAMReadDataValid === 1'b1) spurious++;
    end
    total++;
    if (spurious != 0) begin bad++; $display("FAIL mid_reset_flushed: got %0d valids expected 0", spurious); end
    drive(1'b1, 3'd1, 28'h100, 1'b0, '0);
    for (int i = 0; i < 12 && !found; i++) begin
      idle(1);
      if (DRAMReadDataValid === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL mid_reset_read_timeout: got no valid expected valid within 12 cycles");
    end else begin
      total++;
      if (DRAMReadData !== d6) begin bad++; $display("FAIL mid_reset_array_kept: got %h expected %h", DRAMReadData, d6); end
    end
  endtask

  task automatic test_random();
    logic          cv;
    logic          wv;
    logic [CW-1:0] c;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            r;
    for (int i = 0; i < 460; i++) begin
      r  = int'($urandom_range(0, 19));
      c  = (r < 9) ? 3'd0 : (r < 18) ? 3'd1 : 3'($urandom_range(2, 7));
      a  = {15'($urandom), 10'($urandom_range(0, 15)), 3'($urandom)};
      for (int k = 0; k < DW / 32; k++) wd[k*32 +: 32] = $urandom;
      cv = (i < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      wv = (i < 400) ? ($urandom_range(0, 2) == 0) : 1'b1;
      drive(cv, c, a, wv, wd);
      total++;
      if (DRAMCommandReady !== m_cmd_ready) begin bad++; $display("FAIL rand_cmd_ready cycle %0d: got %b expected %b", i, DRAMCommandReady, m_cmd_ready); end
      total++;
      if (DRAMWriteDataReady !== m_wd_ready) begin bad++; $display("FAIL rand_wd_ready cycle %0d: got %b expected %b", i, DRAMWriteDataReady, m_wd_ready); end
      total++;
      if (DRAMReadDataValid !== m_out_valid) begin bad++; $display("FAIL rand_rd_valid cycle %0d: got %b expected %b", i, DRAMReadDataValid, m_out_valid); end
      if (m_out_known) begin
        total++;
        if (DRAMReadData !== m_out_data) begin bad++; $display("FAIL rand_rd_data cycle %0d: got %h expected %h", i, DRAMReadData, m_out_data); end
      end
      total++;
      if (IllegalCmd !== m_illegal) begin bad++; $display("FAIL rand_illegal cycle %0d: got %b expected %b", i, IllegalCmd, m_illegal); end
    end
  endtask

  initial begin
    Reset              = 1'b1;
    DRAMCommandValid   = 1'b0;
    DRAMCommand        = '0;
    DRAMCommandAddress = '0;
    DRAMWriteDataValid = 1'b0;
    DRAMWriteData      = '0;
    @(negedge Clock);
    test_reset();
    test_read_latency();
    test_data_first();
    test_write_stall();
    test_cmd_full();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
